// File: rtl/cpu_sysid_checker_pkg.sv
// Shared types and constants for the system-ID checker: FSM states,
// result codes and the default identity words of the target slave.
package cpu_sysid_checker_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_ID,
        ST_RD_TS,
        ST_CMP,
        ST_FIN
    } state_e;

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_ID      = 2'b01;
    localparam logic [1:0] ERR_TS      = 2'b10;
    localparam logic [1:0] ERR_TIMEOUT = 2'b11;

    localparam logic [31:0] DEFAULT_EXPECTED_ID = 32'h1111_1111;
    localparam logic [31:0] DEFAULT_EXPECTED_TS = 32'h52FE_6E76;

endpackage

// File: rtl/cpu_sysid_checker_timeout_ctr.sv
// Stall-cycle counter for one Avalon read; flags the TIMEOUT_CYCLES-th
// stalled cycle so the master can drop the read on the following edge.
module sysid_timeout_ctr #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic i_clock,
    input  logic i_reset_n,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_terminal
);

    localparam logic [15:0] TERMINAL_VALUE = 16'(TIMEOUT_CYCLES - 1);

    logic [15:0] r_count;

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable) begin
            r_count <= r_count + 16'd1;
        end
    end

    // Terminal fires during the stalled cycle that brings the count to the limit.
    assign o_terminal = i_enable && (r_count == TERMINAL_VALUE);

endmodule

// File: rtl/cpu_sysid_checker.sv
// Avalon-MM master that reads the system ID and timestamp words from a
// sysid slave, compares them with the expected values and retries on failure.
module cpu_sysid_checker
    import cpu_sysid_checker_pkg::*;
#(
    parameter logic [31:0] EXPECTED_ID    = DEFAULT_EXPECTED_ID,
    parameter logic [31:0] EXPECTED_TS    = DEFAULT_EXPECTED_TS,
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned MAX_RETRIES    = 3
) (
    input  logic        i_clock,
    input  logic        i_reset_n,
    input  logic        i_start,
    output logic        o_avm_address,
    output logic        o_avm_read,
    input  logic        i_avm_waitrequest,
    input  logic [31:0] i_avm_readdata,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_pass,
    output logic [1:0]  o_err_code,
    output logic [31:0] o_id_value,
    output logic [31:0] o_ts_value,
    output logic [3:0]  o_attempts
);

    state_e      r_state;
    logic        r_avmRead;
    logic        r_avmAddress;
    logic        r_busy;
    logic        r_done;
    logic        r_pass;
    logic        r_timedOut;
    logic [1:0]  r_errCode;
    logic [31:0] r_idValue;
    logic [31:0] r_tsValue;
    logic [3:0]  r_attempts;

    logic        w_inRead;
    logic        w_stall;
    logic        w_readDone;
    logic        w_startAccept;
    logic        w_ctrClear;
    logic        w_timeout;
    logic        w_retryOk;
    logic [1:0]  w_cmpErr;

    assign w_inRead      = (r_state == ST_RD_ID) || (r_state == ST_RD_TS);
    assign w_stall       = w_inRead && r_avmRead && i_avm_waitrequest;
    assign w_readDone    = w_inRead && r_avmRead && !i_avm_waitrequest;
    assign w_startAccept = (r_state == ST_IDLE) && i_start;
    assign w_ctrClear    = w_startAccept || w_readDone || w_timeout || (r_state == ST_CMP);
    assign w_retryOk     = (32'(r_attempts) <= MAX_RETRIES);

    sysid_timeout_ctr #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeoutCtr (
        .i_clock   (i_clock),
        .i_reset_n (i_reset_n),
        .i_clear   (w_ctrClear),
        .i_enable  (w_stall),
        .o_terminal(w_timeout)
    );

    // A timed-out attempt outranks any comparison of stale captured words.
    always_comb begin
        w_cmpErr = ERR_NONE;
        if (r_timedOut) begin
            w_cmpErr = ERR_TIMEOUT;
        end else if (r_idValue != EXPECTED_ID) begin
            w_cmpErr = ERR_ID;
        end else if (r_tsValue != EXPECTED_TS) begin
            w_cmpErr = ERR_TS;
        end
    end

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state      <= ST_IDLE;
            r_avmRead    <= 1'b0;
            r_avmAddress <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_pass       <= 1'b0;
            r_timedOut   <= 1'b0;
            r_errCode    <= ERR_NONE;
            r_idValue    <= '0;
            r_tsValue    <= '0;
            r_attempts   <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (i_start) begin
                        r_state      <= ST_RD_ID;
                        r_busy       <= 1'b1;
                        r_pass       <= 1'b0;
                        r_errCode    <= ERR_NONE;
                        r_attempts   <= 4'd1;
                        r_timedOut   <= 1'b0;
                        r_avmRead    <= 1'b1;
                        r_avmAddress <= 1'b0;
                    end
                end
                ST_RD_ID: begin
                    if (w_readDone) begin
                        r_idValue    <= i_avm_readdata;
                        r_avmAddress <= 1'b1;
                        r_state      <= ST_RD_TS;
                    end else if (w_timeout) begin
                        r_avmRead  <= 1'b0;
                        r_timedOut <= 1'b1;
                        r_errCode  <= ERR_TIMEOUT;
                        r_state    <= ST_CMP;
                    end
                end
                ST_RD_TS: begin
                    if (w_readDone) begin
                        r_tsValue <= i_avm_readdata;
                        r_avmRead <= 1'b0;
                        r_state   <= ST_CMP;
                    end else if (w_timeout) begin
                        r_avmRead  <= 1'b0;
                        r_timedOut <= 1'b1;
                        r_errCode  <= ERR_TIMEOUT;
                        r_state    <= ST_CMP;
                    end
                end
                ST_CMP: begin
                    r_errCode <= w_cmpErr;
                    if (w_cmpErr == ERR_NONE) begin
                        r_pass  <= 1'b1;
                        r_done  <= 1'b1;
                        r_state <= ST_FIN;
                    end else if (w_retryOk) begin
                        r_attempts   <= r_attempts + 4'd1;
                        r_timedOut   <= 1'b0;
                        r_avmRead    <= 1'b1;
                        r_avmAddress <= 1'b0;
                        r_state      <= ST_RD_ID;
                    end else begin
                        r_pass  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= ST_FIN;
                    end
                end
                ST_FIN: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_avm_address = r_avmAddress;
    assign o_avm_read    = r_avmRead;
    assign o_busy        = r_busy;
    assign o_done        = r_done;
    assign o_pass        = r_pass;
    assign o_err_code    = r_errCode;
    assign o_id_value    = r_idValue;
    assign o_ts_value    = r_tsValue;
    assign o_attempts    = r_attempts;

endmodule

// File: tb/tb_cpu_sysid_checker.sv
// Directed bench for cpu_sysid_checker: a vector table of slave behaviours
// plus hand-written sequences for reset, start filtering and timeout.
module tb_cpu_sysid_checker;
    import cpu_sysid_checker_pkg::*;

    localparam logic [31:0] GOOD_ID = 32'h1111_1111;
    localparam logic [31:0] GOOD_TS = 32'h52FE_6E76;
    localparam logic [31:0] BAD_ID  = 32'h1111_1112;
    localparam logic [31:0] BAD_TS  = 32'hDEAD_BEEF;

    typedef struct {
        logic [31:0] idWord;
        logic [31:0] tsWord;
        int          badTs;
        int          stall;
        logic        expPass;
        logic [1:0]  expErr;
        logic [3:0]  expAtt;
        int          expLat;
    } vector_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rstMain, startMain, readMain, addrMain, waitMain;
    logic        busyMain, doneMain, passMain;
    logic [1:0]  errMain;
    logic [31:0] dataMain, idMain, tsMain;
    logic [3:0]  attMain;

    logic        rstTo, startTo, readTo, addrTo, waitTo;
    logic        busyTo, doneTo, passTo;
    logic [1:0]  errTo;
    logic [31:0] dataTo, idTo, tsTo;
    logic [3:0]  attTo;

    logic [31:0] idWord, tsWord;
    int          badTsReads, stallCycles;
    logic        holdTs;
    int          stallCtr, tsReadCount;

    int assertCount = 0;
    int failCount   = 0;

    cpu_sysid_checker dut (
        .i_clock          (clk),
        .i_reset_n        (rstMain),
        .i_start          (startMain),
        .o_avm_address    (addrMain),
        .o_avm_read       (readMain),
        .i_avm_waitrequest(waitMain),
        .i_avm_readdata   (dataMain),
        .o_busy           (busyMain),
        .o_done           (doneMain),
        .o_pass           (passMain),
        .o_err_code       (errMain),
        .o_id_value       (idMain),
        .o_ts_value       (tsMain),
        .o_attempts       (attMain)
    );

    cpu_sysid_checker #(
        .TIMEOUT_CYCLES(4),
        .MAX_RETRIES   (0)
    ) dutTo (
        .i_clock          (clk),
        .i_reset_n        (rstTo),
        .i_start          (startTo),
        .o_avm_address    (addrTo),
        .o_avm_read       (readTo),
        .i_avm_waitrequest(waitTo),
        .i_avm_readdata   (dataTo),
        .o_busy           (busyTo),
        .o_done           (doneTo),
        .o_pass           (passTo),
        .o_err_code       (errTo),
        .o_id_value       (idTo),
        .o_ts_value       (tsTo),
        .o_attempts       (attTo)
    );

    // Slave model: stalls each read stallCycles cycles, optionally stalls the
    // TS read forever, and returns BAD_TS for the first badTsReads TS reads.
    always @(posedge clk) begin
        if (startMain && !busyMain) begin
            stallCtr    <= 0;
            tsReadCount <= 0;
        end else if (readMain) begin
            if (waitMain) begin
                stallCtr <= stallCtr + 1;
            end else begin
                stallCtr <= 0;
                if (addrMain) tsReadCount <= tsReadCount + 1;
            end
        end
    end

    assign waitMain = readMain && ((stallCtr < stallCycles) || (holdTs && addrMain));
    assign dataMain = addrMain ? ((tsReadCount < badTsReads) ? BAD_TS : tsWord) : idWord;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, " avm_read"}, 32'(readMain), 32'd0);
        checkOutput({tag, " avm_address"}, 32'(addrMain), 32'd0);
        checkOutput({tag, " busy"}, 32'(busyMain), 32'd0);
        checkOutput({tag, " done"}, 32'(doneMain), 32'd0);
        checkOutput({tag, " pass"}, 32'(passMain), 32'd0);
        checkOutput({tag, " err_code"}, 32'(errMain), 32'd0);
        checkOutput({tag, " id_value"}, idMain, 32'd0);
        checkOutput({tag, " ts_value"}, tsMain, 32'd0);
        checkOutput({tag, " attempts"}, 32'(attMain), 32'd0);
    endtask

    task automatic waitDone(input int firstLat, output int lat);
        lat = firstLat;
        while (!doneMain && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        if (!doneMain) lat = -1;
    endtask

    task automatic runCheck(output int lat);
        startMain = 1'b1;
        @(negedge clk);
        startMain = 1'b0;
        waitDone(1, lat);
    endtask

    task automatic applyStimulus(input int idx, input vector_t v);
        int lat;
        idWord      = v.idWord;
        tsWord      = v.tsWord;
        badTsReads  = v.badTs;
        stallCycles = v.stall;
        holdTs      = 1'b0;
        runCheck(lat);
        checkOutput($sformatf("vec%0d latency", idx), 32'(lat), 32'(v.expLat));
        checkOutput($sformatf("vec%0d pass", idx), 32'(passMain), 32'(v.expPass));
        checkOutput($sformatf("vec%0d err_code", idx), 32'(errMain), 32'(v.expErr));
        checkOutput($sformatf("vec%0d attempts", idx), 32'(attMain), 32'(v.expAtt));
        checkOutput($sformatf("vec%0d id_value", idx), idMain, v.idWord);
        checkOutput($sformatf("vec%0d ts_value", idx), tsMain, v.tsWord);
        checkOutput($sformatf("vec%0d busy in done", idx), 32'(busyMain), 32'd1);
        @(negedge clk);
        checkOutput($sformatf("vec%0d done width", idx), 32'(doneMain), 32'd0);
        checkOutput($sformatf("vec%0d busy idle", idx), 32'(busyMain), 32'd0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, expected $finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vector_t vecs[7];
        int      lat;
        int      toReadCycles, toDoneCycle;
        logic    toReadAt4, toReadAt5, toAddrAt4, doneSeen;
        logic [1:0] toErrAtDone;
        logic    toPassAtDone;
        logic [3:0] toAttAtDone;

        vecs[0] = '{GOOD_ID, GOOD_TS, 0, 0, 1'b1, 2'b00, 4'd1, 4};
        vecs[1] = '{BAD_ID,  GOOD_TS, 0, 0, 1'b0, 2'b01, 4'd4, 13};
        vecs[2] = '{GOOD_ID, 32'h0,   0, 0, 1'b0, 2'b10, 4'd4, 13};
        vecs[3] = '{BAD_ID,  32'h0,   0, 0, 1'b0, 2'b01, 4'd4, 13};
        vecs[4] = '{GOOD_ID, GOOD_TS, 1, 0, 1'b1, 2'b00, 4'd2, 7};
        vecs[5] = '{GOOD_ID, GOOD_TS, 0, 2, 1'b1, 2'b00, 4'd1, 8};
        vecs[6] = '{BAD_ID,  GOOD_TS, 0, 1, 1'b0, 2'b01, 4'd4, 21};

        idWord = GOOD_ID; tsWord = GOOD_TS;
        badTsReads = 0; stallCycles = 0; holdTs = 1'b0;
        rstMain = 1'b0; rstTo = 1'b0;
        startMain = 1'b0; startTo = 1'b0;
        waitTo = 1'b1; dataTo = 32'h0;

        #1;
        checkResetValues("por");
        @(negedge clk);
        @(negedge clk);
        checkResetValues("reset held");
        rstMain = 1'b1;
        rstTo   = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 7; i++) begin
            applyStimulus(i, vecs[i]);
        end

        // Cycle-by-cycle view of a zero-wait attempt.
        idWord = GOOD_ID; tsWord = GOOD_TS; badTsReads = 0; stallCycles = 0;
        startMain = 1'b1;
        @(negedge clk);
        startMain = 1'b0;
        checkOutput("c1 read", 32'(readMain), 32'd1);
        checkOutput("c1 address", 32'(addrMain), 32'd0);
        checkOutput("c1 busy", 32'(busyMain), 32'd1);
        @(negedge clk);
        checkOutput("c2 read", 32'(readMain), 32'd1);
        checkOutput("c2 address", 32'(addrMain), 32'd1);
        @(negedge clk);
        checkOutput("c3 read", 32'(readMain), 32'd0);
        checkOutput("c3 done", 32'(doneMain), 32'd0);
        @(negedge clk);
        checkOutput("c4 done", 32'(doneMain), 32'd1);
        @(negedge clk);
        checkOutput("c5 done", 32'(doneMain), 32'd0);

        // Start while busy and in the done cycle must be ignored.
        idWord = BAD_ID;
        startMain = 1'b1;
        @(negedge clk);
        startMain = 1'b0;
        lat = 1;
        while (!doneMain && lat < 200) begin
            startMain = (lat == 2);
            @(negedge clk);
            lat++;
        end
        startMain = 1'b0;
        if (!doneMain) lat = -1;
        checkOutput("ignored-start latency", 32'(lat), 32'd13);
        startMain = 1'b1;
        @(negedge clk);
        startMain = 1'b0;
        checkOutput("ignored-start busy", 32'(busyMain), 32'd0);
        checkOutput("ignored-start attempts", 32'(attMain), 32'd4);
        checkOutput("ignored-start err_code", 32'(errMain), 32'd1);
        checkOutput("ignored-start pass", 32'(passMain), 32'd0);
        checkOutput("ignored-start read", 32'(readMain), 32'd0);

        // Start in the IDLE cycle right after FIN is accepted.
        idWord = GOOD_ID;
        startMain = 1'b1;
        @(negedge clk);
        startMain = 1'b0;
        checkOutput("post-fin start busy", 32'(busyMain), 32'd1);
        checkOutput("post-fin start attempts", 32'(attMain), 32'd1);
        checkOutput("post-fin start err_code", 32'(errMain), 32'd0);
        waitDone(1, lat);
        checkOutput("post-fin latency", 32'(lat), 32'd4);
        checkOutput("post-fin pass", 32'(passMain), 32'd1);
        @(negedge clk);

        // Reset while the TS read is stalled.
        holdTs = 1'b1;
        startMain = 1'b1;
        @(negedge clk);
        startMain = 1'b0;
        checkOutput("mid-rst RD_ID address", 32'(addrMain), 32'd0);
        for (int c = 2; c <= 4; c++) begin
            @(negedge clk);
            checkOutput($sformatf("stall c%0d read", c), 32'(readMain), 32'd1);
            checkOutput($sformatf("stall c%0d address", c), 32'(addrMain), 32'd1);
        end
        rstMain = 1'b0;
        #1;
        checkResetValues("mid-read reset");
        doneSeen = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (doneMain) doneSeen = 1'b1;
        end
        rstMain = 1'b1;
        holdTs  = 1'b0;
        @(negedge clk);
        if (doneMain) doneSeen = 1'b1;
        checkOutput("no done after reset", 32'(doneSeen), 32'd0);
        runCheck(lat);
        checkOutput("after-reset latency", 32'(lat), 32'd4);
        checkOutput("after-reset pass", 32'(passMain), 32'd1);
        checkOutput("after-reset attempts", 32'(attMain), 32'd1);
        checkOutput("after-reset err_code", 32'(errMain), 32'd0);
        @(negedge clk);

        // Timeout instance: slave stalls forever, TIMEOUT_CYCLES=4, no retries.
        startTo = 1'b1;
        @(negedge clk);
        startTo = 1'b0;
        toReadCycles = 0; toDoneCycle = 0;
        toReadAt4 = 1'b0; toReadAt5 = 1'b1; toAddrAt4 = 1'b1;
        toErrAtDone = 2'b00; toPassAtDone = 1'b1; toAttAtDone = 4'd0;
        for (int c = 1; c <= 12; c++) begin
            if (readTo) toReadCycles++;
            if (c == 4) begin toReadAt4 = readTo; toAddrAt4 = addrTo; end
            if (c == 5) toReadAt5 = readTo;
            if (doneTo && toDoneCycle == 0) begin
                toDoneCycle  = c;
                toErrAtDone  = errTo;
                toPassAtDone = passTo;
                toAttAtDone  = attTo;
            end
            @(negedge clk);
        end
        checkOutput("timeout read cycles", 32'(toReadCycles), 32'd4);
        checkOutput("timeout read at c4", 32'(toReadAt4), 32'd1);
        checkOutput("timeout address at c4", 32'(toAddrAt4), 32'd0);
        checkOutput("timeout read at c5", 32'(toReadAt5), 32'd0);
        checkOutput("timeout done cycle", 32'(toDoneCycle), 32'd6);
        checkOutput("timeout err_code", 32'(toErrAtDone), 32'd3);
        checkOutput("timeout pass", 32'(toPassAtDone), 32'd0);
        checkOutput("timeout attempts", 32'(toAttAtDone), 32'd1);
        checkOutput("timeout id_value", idTo, 32'd0);
        checkOutput("timeout ts_value", tsTo, 32'd0);
        checkOutput("timeout busy idle", 32'(busyTo), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
